// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage MIPS pipeline control logic.
//   REG_ADDR_W     : width of a register-file address field
//   REG_ZERO       : address of the hard-wired zero register ($zero)
//   md_state_t     : mul/div tracker FSM state encoding
//   MD_LAT_DEFAULT : default mul/div latency in cycles
// ----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int MD_LAT_DEFAULT = 32;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_t;

    // A source register only creates a dependence when it is actually read
    // and names the same register the producer writes.
    function automatic logic reg_match(
        input logic                  use_src,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst
    );
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_tracker.sv
// ----------------------------------------------------------------------------
// md_tracker
// Tracks the in-flight multi-cycle mul/div operation.
// Ports:
//   clk      in   core clock
//   rst      in   asynchronous reset, active-low
//   md_start in   one-cycle start pulse (already qualified by the caller)
//   md_busy  out  high while a mul/div result is not yet valid in HI/LO
// Parameters:
//   MD_LAT   mul/div latency from md_start to result valid (2..255)
//   CNT_W    countdown counter width (must hold MD_LAT)
// ----------------------------------------------------------------------------
module md_tracker
    import pipeline_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT,
    parameter int CNT_W  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start,
    output logic md_busy
);

    md_state_t        state;
    md_state_t        state_next;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] md_cnt_next;

    // State register; reset aborts any tracking immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    // The counter is loaded with MD_LAT-1 because the start cycle itself is
    // the first cycle of latency; leaving MD_WAIT when the count reaches 1
    // frees a HI/LO reader in exactly the cycle the result becomes valid.
    always_comb begin
        state_next  = state;
        md_cnt_next = md_cnt;
        case (state)
            RUN: begin
                if (md_start) begin
                    state_next  = MD_WAIT;
                    md_cnt_next = CNT_W'(MD_LAT - 1);
                end
            end
            MD_WAIT: begin
                if (md_cnt == CNT_W'(1)) begin
                    state_next  = RUN;
                    md_cnt_next = '0;
                end else begin
                    md_cnt_next = md_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next  = RUN;
                md_cnt_next = '0;
            end
        endcase
    end

    assign md_busy = (state == MD_WAIT);

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencer for the 5-stage MIPS core. Drives enables and flushes of
// the PC, IF_ID and ID_EX registers from load-use hazards, taken branches
// resolved in EX and the multi-cycle mul/div unit.
// Ports:
//   clk, rst (async, active-low)
//   ID_rs, ID_rt, ID_useRs, ID_useRt   source operands of the ID instruction
//   ID_isMulDiv, ID_readsHiLo          ID instruction mul/div or mfhi/mflo
//   EX_memRead, EX_rd                  EX instruction is a load to EX_rd
//   EX_branchTaken                     branch/jump in EX resolved taken
//   pc_en, IF_ID_en                    register update enables
//   IF_ID_flush, ID_EX_flush           load NOP / bubble
//   md_start                           one-cycle start to the mul/div unit
//   md_busy                            mul/div in flight
// Optional build macro HAZARD_STATS_EN adds stall_cnt / flush_cnt outputs.
// ----------------------------------------------------------------------------
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ID_rs,
    input  logic [REG_ADDR_W-1:0] ID_rt,
    input  logic                  ID_useRs,
    input  logic                  ID_useRt,
    input  logic                  ID_isMulDiv,
    input  logic                  ID_readsHiLo,
    input  logic                  EX_memRead,
    input  logic [REG_ADDR_W-1:0] EX_rd,
    input  logic                  EX_branchTaken,
`ifdef HAZARD_STATS_EN
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt,
`endif
    output logic                  pc_en,
    output logic                  IF_ID_en,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_flush,
    output logic                  md_start,
    output logic                  md_busy
);

    logic load_use;
    logic md_hazard;
    logic stall;
    logic busy;

    // Writes to $zero are discarded, so they never create a dependence.
    assign load_use = EX_memRead && (EX_rd != REG_ZERO) &&
                      (reg_match(ID_useRs, ID_rs, EX_rd) ||
                       reg_match(ID_useRt, ID_rt, EX_rd));

    assign md_hazard = busy && (ID_isMulDiv || ID_readsHiLo);
    assign stall     = load_use || md_hazard;

    md_tracker #(
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) u_md_tracker (
        .clk      (clk),
        .rst      (rst),
        .md_start (md_start),
        .md_busy  (busy)
    );

    // Output priority: a taken branch wins over any stall because the stalled
    // ID instruction is on the wrong path. While reset is held the pipeline is
    // frozen and filled with bubbles.
    always_comb begin
        pc_en       = 1'b1;
        IF_ID_en    = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        md_start    = 1'b0;
        md_busy     = busy;
        if (!rst) begin
            pc_en       = 1'b0;
            IF_ID_en    = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            md_busy     = 1'b0;
        end else if (EX_branchTaken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (stall) begin
            pc_en       = 1'b0;
            IF_ID_en    = 1'b0;
            ID_EX_flush = 1'b1;
        end else begin
            md_start    = ID_isMulDiv;
        end
    end

`ifdef HAZARD_STATS_EN
    // Stall cycles hidden by a redirect are counted as flushes only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !EX_branchTaken) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (EX_branchTaken) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl (MD_LAT=4): table of single-cycle
// vectors, hand-written multi-cycle sequences and randomized stimulus
// against a reference model that tracks mul/div as "cycles left busy".
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int LAT = 4;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       useRs;
        logic       useRt;
        logic       isMulDiv;
        logic       readsHiLo;
        logic       memRead;
        logic [4:0] rd;
        logic       branch;
    } stim_t;

    typedef struct {
        stim_t      in;
        logic [5:0] exp;
    } vec_t;

    // Output packing: {pc_en, IF_ID_en, IF_ID_flush, ID_EX_flush, md_start, md_busy}
    localparam logic [5:0] O_RESET  = 6'b001100;
    localparam logic [5:0] O_RUN    = 6'b110000;
    localparam logic [5:0] O_STALL  = 6'b000100;
    localparam logic [5:0] O_BRANCH = 6'b111100;
    localparam logic [5:0] O_START  = 6'b110010;
    localparam logic [5:0] O_BUSY   = 6'b110001;
    localparam logic [5:0] O_MDSTL  = 6'b000101;
    localparam logic [5:0] O_BRBUSY = 6'b111101;

    logic       clk;
    logic       rst;
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_useRs;
    logic       ID_useRt;
    logic       ID_isMulDiv;
    logic       ID_readsHiLo;
    logic       EX_memRead;
    logic [4:0] EX_rd;
    logic       EX_branchTaken;
    logic       pc_en;
    logic       IF_ID_en;
    logic       IF_ID_flush;
    logic       ID_EX_flush;
    logic       md_start;
    logic       md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int testCount = 0;
    int failCount = 0;
    int busyLeft  = 0;

    hazard_ctrl #(
        .MD_LAT (LAT),
        .CNT_W  (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_rs          (ID_rs),
        .ID_rt          (ID_rt),
        .ID_useRs       (ID_useRs),
        .ID_useRt       (ID_useRt),
        .ID_isMulDiv    (ID_isMulDiv),
        .ID_readsHiLo   (ID_readsHiLo),
        .EX_memRead     (EX_memRead),
        .EX_rd          (EX_rd),
        .EX_branchTaken (EX_branchTaken),
`ifdef HAZARD_STATS_EN
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
`endif
        .pc_en          (pc_en),
        .IF_ID_en       (IF_ID_en),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_flush    (ID_EX_flush),
        .md_start       (md_start),
        .md_busy        (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference outputs from the rules, given how many busy cycles remain.
    function automatic logic [5:0] refOut(input stim_t s, input int left, input logic rstN);
        logic busy, loadUse, stall;
        if (!rstN) return O_RESET;
        busy    = (left > 0);
        loadUse = s.memRead && (s.rd != 5'd0) &&
                  ((s.useRs && s.rs == s.rd) || (s.useRt && s.rt == s.rd));
        stall   = loadUse || (busy && (s.isMulDiv || s.readsHiLo));
        if (s.branch) return {4'b1111, 1'b0, busy};
        if (stall)    return {4'b0001, 1'b0, busy};
        return {4'b1100, s.isMulDiv, busy};
    endfunction

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic useRs, input logic useRt,
                                 input logic isMD, input logic hilo,
                                 input logic memRead, input logic [4:0] rd,
                                 input logic branch);
        stim_t s;
        s.rs = rs; s.rt = rt; s.useRs = useRs; s.useRt = useRt;
        s.isMulDiv = isMD; s.readsHiLo = hilo; s.memRead = memRead;
        s.rd = rd; s.branch = branch;
        return s;
    endfunction

    function automatic logic [5:0] dutOut();
        return {pc_en, IF_ID_en, IF_ID_flush, ID_EX_flush, md_start, md_busy};
    endfunction

    task automatic drive(input stim_t s);
        ID_rs          = s.rs;
        ID_rt          = s.rt;
        ID_useRs       = s.useRs;
        ID_useRt       = s.useRt;
        ID_isMulDiv    = s.isMulDiv;
        ID_readsHiLo   = s.readsHiLo;
        EX_memRead     = s.memRead;
        EX_rd          = s.rd;
        EX_branchTaken = s.branch;
    endtask

    task automatic checkOutput(input string name, input int id,
                               input logic [5:0] actual, input logic [5:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s[%0d]: got %b expected %b (pc_en,IF_ID_en,IF_ID_flush,ID_EX_flush,md_start,md_busy)",
                     name, id, actual, expected);
        end
    endtask

    // Called just after a rising edge: drive, check mid-cycle, clock the model.
    task automatic applyStimulus(input string name, input int id,
                                 input stim_t s, input logic [5:0] expected);
        logic [5:0] m;
        drive(s);
        #2;
        checkOutput(name, id, dutOut(), expected);
        m = refOut(s, busyLeft, rst);
        @(posedge clk);
        if (!rst)             busyLeft = 0;
        else if (busyLeft > 0) busyLeft--;
        else if (m[1])         busyLeft = LAT - 1;
        #1;
    endtask

    vec_t  vecs[$];
    stim_t idle;
    stim_t s;

    initial begin
        idle = mk(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0);

        // Single-cycle vectors, all with the mul/div unit idle.
        vecs.push_back('{mk(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0), O_RUN});
        vecs.push_back('{mk(5'd8, 5'd3, 1, 0, 0, 0, 1, 5'd8, 0), O_STALL});
        vecs.push_back('{mk(5'd8, 5'd3, 1, 0, 0, 0, 0, 5'd0, 0), O_RUN});
        vecs.push_back('{mk(5'd0, 5'd0, 1, 1, 0, 0, 1, 5'd0, 0), O_RUN});
        vecs.push_back('{mk(5'd2, 5'd9, 1, 1, 0, 0, 1, 5'd9, 0), O_STALL});
        vecs.push_back('{mk(5'd8, 5'd8, 0, 0, 0, 0, 1, 5'd8, 0), O_RUN});
        vecs.push_back('{mk(5'd8, 5'd3, 1, 0, 0, 0, 0, 5'd8, 0), O_RUN});
        vecs.push_back('{mk(5'd8, 5'd3, 1, 0, 0, 0, 1, 5'd8, 1), O_BRANCH});
        vecs.push_back('{mk(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 1), O_BRANCH});
        vecs.push_back('{mk(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0), O_RUN});
        vecs.push_back('{mk(5'd4, 5'd5, 0, 1, 1, 0, 1, 5'd5, 0), O_STALL});
        vecs.push_back('{mk(5'd4, 5'd5, 0, 1, 0, 0, 1, 5'd4, 0), O_RUN});

        // Reset held with random inputs.
        rst = 1'b0;
        drive(idle);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            s = stim_t'($urandom);
            applyStimulus("reset_hold", i, s, O_RESET);
        end
        rst = 1'b1;
        applyStimulus("reset_release", 0, idle, O_RUN);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus("table", i, vecs[i].in, vecs[i].exp);
        end
        applyStimulus("load_use_one_cycle", 0, mk(5'd8, 5'd0, 1, 0, 0, 0, 1, 5'd8, 0), O_STALL);
        applyStimulus("load_use_one_cycle", 1, mk(5'd8, 5'd0, 1, 0, 0, 0, 0, 5'd8, 0), O_RUN);

        // Mul/div then mfhi held: stalled for LAT-1 cycles, released on the LAT-th.
        applyStimulus("md_start", 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0), O_START);
        for (int i = 0; i < LAT - 1; i++)
            applyStimulus("hilo_wait", i, mk(0, 0, 0, 0, 0, 1, 0, 0, 0), O_MDSTL);
        applyStimulus("hilo_release", 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0), O_RUN);

        // Back-to-back mul/div, with a redirect while the second is in flight.
        applyStimulus("b2b_first", 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0), O_START);
        for (int i = 0; i < LAT - 1; i++)
            applyStimulus("b2b_stall", i, mk(0, 0, 0, 0, 1, 0, 0, 0, 0), O_MDSTL);
        applyStimulus("b2b_second", 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0), O_START);
        applyStimulus("b2b_busy", 0, idle, O_BUSY);
        applyStimulus("branch_in_wait", 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 1), O_BRBUSY);
        applyStimulus("b2b_busy", 1, idle, O_BUSY);
        applyStimulus("b2b_done", 0, idle, O_RUN);

        // Asynchronous reset between edges while waiting on a mul/div.
        applyStimulus("abort_start", 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0), O_START);
        applyStimulus("abort_busy", 0, idle, O_BUSY);
        drive(idle);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset", 0, dutOut(), O_RESET);
        busyLeft = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus("after_reset", 0, idle, O_RUN);
        applyStimulus("restart", 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0), O_START);
        for (int i = 0; i < LAT - 1; i++)
            applyStimulus("restart_busy", i, idle, O_BUSY);
        applyStimulus("restart_done", 0, idle, O_RUN);

        // Randomized run against the reference model.
        for (int i = 0; i < 400; i++) begin
            s.rs        = 5'($urandom_range(0, 3));
            s.rt        = 5'($urandom_range(0, 3));
            s.rd        = 5'($urandom_range(0, 3));
            s.useRs     = 1'($urandom);
            s.useRt     = 1'($urandom);
            s.memRead   = 1'($urandom);
            s.isMulDiv  = ($urandom_range(0, 3) == 0);
            s.readsHiLo = ($urandom_range(0, 3) == 0);
            s.branch    = ($urandom_range(0, 7) == 0);
            applyStimulus("random", i, s, refOut(s, busyLeft, rst));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS core; drives the enables and flushes of the PC, IF_ID and ID_EX pipeline registers.
- Detects load-use hazards, redirects on taken branches/jumps resolved in EX, and tracks the multi-cycle mul/div unit.
- Stalls HI/LO consumers and back-to-back mul/div until the unit completes.
- Sits beside the pipeline registers in the core top; purely control, no datapath.

Parameters:
- MD_LAT, 32, mul/div latency in cycles from md_start to result valid in HI/LO (legal 2..255).
- CNT_W, 8, width of the mul/div countdown counter (must hold MD_LAT).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- ID_rs  in  5  rs field of the instruction in ID
- ID_rt  in  5  rt field of the instruction in ID
- ID_useRs  in  1  ID instruction reads rs
- ID_useRt  in  1  ID instruction reads rt
- ID_isMulDiv  in  1  ID instruction is mult/multu/div/divu
- ID_readsHiLo  in  1  ID instruction is mfhi/mflo
- EX_memRead  in  1  EX instruction is a load
- EX_rd  in  5  destination register of the EX instruction
- EX_branchTaken  in  1  branch/jump in EX resolved taken
- pc_en  out  1  PC register update enable
- IF_ID_en  out  1  IF_ID load enable
- IF_ID_flush  out  1  IF_ID loads a NOP
- ID_EX_flush  out  1  ID_EX loads a bubble
- md_start  out  1  one-cycle start pulse to the mul/div unit
- md_busy  out  1  mul/div in flight

Behaviour:
- State: FSM {RUN, MD_WAIT} plus CNT_W-bit down-counter md_cnt.
- Reset (rst=0, async): state=RUN, md_cnt=0. Outputs while in reset: pc_en=0, IF_ID_en=0, IF_ID_flush=1, ID_EX_flush=1, md_start=0, md_busy=0.
- Outputs are combinational from the inputs and the registered state; state updates on posedge clk.
- load_use = EX_memRead & EX_rd!=0 & ((ID_useRs & ID_rs==EX_rd) | (ID_useRt & ID_rt==EX_rd)).
- md_hazard = md_busy & (ID_isMulDiv | ID_readsHiLo).
- stall = load_use | md_hazard.
- md_busy = (state==MD_WAIT).
- Priority:
  - 1: EX_branchTaken → pc_en=1, IF_ID_en=1, IF_ID_flush=1, ID_EX_flush=1, md_start=0. The redirect overrides any stall: the stalled ID instruction is on the wrong path.
  - 2: stall → pc_en=0, IF_ID_en=0, IF_ID_flush=0, ID_EX_flush=1, md_start=0.
  - 3: otherwise → pc_en=1, IF_ID_en=1, both flushes 0.
- md_start = ID_isMulDiv & !stall & !EX_branchTaken.
- RUN:
  - md_start → MD_WAIT, md_cnt=MD_LAT-1.
  - Otherwise stay in RUN.
- MD_WAIT:
  - md_cnt decrements each cycle.
  - When md_cnt==1 at the clock edge → RUN, md_cnt=0.
  - A HI/LO reader is therefore released in the cycle the result is valid.
- Load-use stall lasts exactly one cycle: the load advances to MEM and forwarding covers it.
- Load-use and md_hazard may coincide; stall persists until both clear.
- A branch flush while MD_WAIT does not cancel the mul/div: it was architecturally issued earlier.
- Reset asserted mid-MD_WAIT aborts tracking; state returns to RUN immediately.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on cycles with stall & !EX_branchTaken.
  - flush_cnt increments on cycles with EX_branchTaken.
  - Both wrap at 2^32 and clear on reset.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package pipeline_pkg:
  - REG_ADDR_W=5
  - REG_ZERO=5'd0
  - FSM state encoding (RUN=1'b0, MD_WAIT=1'b1)
  - default MD_LAT
- One sub-module: md_tracker.
  - Holds the FSM and md_cnt.
  - Inputs: clk, rst, md_start.
  - Output: md_busy.
- Hazard detection and output priority stay in hazard_ctrl.

Test Plan:
- Reset: hold rst=0 with random inputs → pc_en=0, IF_ID_en=0, both flushes=1, md_busy=0. Release → pc_en=1 next cycle with idle inputs.
- Load-use: EX_memRead=1, EX_rd=8, ID_rs=8, ID_useRs=1 for one cycle → pc_en=0, IF_ID_en=0, ID_EX_flush=1 that cycle only. Repeat with EX_rd=0 → no stall.
- Mul/div: ID_isMulDiv=1 with MD_LAT=4 → md_start pulse for one cycle, md_busy high for exactly 3 cycles. ID_readsHiLo held during that window → stall in those 3 cycles, released on the 4th.
- Branch over stall: EX_branchTaken=1 coincident with load_use → pc_en=1, IF_ID_flush=1, ID_EX_flush=1. Same coincident with ID_isMulDiv → md_start=0.
- Back-to-back mul/div: second ID_isMulDiv issued during md_busy → stalled until busy drops, then md_start fires once.
- Async reset mid-MD_WAIT (cycle 2 of 32), asserted between clock edges → md_busy=0 immediately. After release, a new mul/div starts cleanly.
